// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports plus one synchronous write port.
interface reg_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_addr_0;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [DATA_WIDTH-1:0] read_data_0;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output read_addr_0, read_addr_1, write_enable, write_addr, write_data,
        input  read_data_0, read_data_1
    );

    modport slave (
        input  read_addr_0, read_addr_1, write_enable, write_addr, write_data,
        output read_data_0, read_data_1
    );
endinterface

// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports with write-first bypass,
// one synchronous write port, optional hardwired-zero register 0.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_ok;

    // A write to the hardwired zero register is treated as no write at all.
    assign write_ok = bus.write_enable &&
                      !(ZERO_REG && (bus.write_addr == ADDR_WIDTH'(0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (write_ok) begin
            regs[bus.write_addr] <= bus.write_data;
        end
    end

    // Read port 0: rst, then zero register, then bypass, then stored value.
    always_comb begin
        bus.read_data_0 = regs[bus.read_addr_0];
        if (rst) begin
            bus.read_data_0 = '0;
        end else if (ZERO_REG && (bus.read_addr_0 == ADDR_WIDTH'(0))) begin
            bus.read_data_0 = '0;
        end else if (write_ok && (bus.write_addr == bus.read_addr_0)) begin
            bus.read_data_0 = bus.write_data;
        end
    end

    // Read port 1: same resolution as port 0.
    always_comb begin
        bus.read_data_1 = regs[bus.read_addr_1];
        if (rst) begin
            bus.read_data_1 = '0;
        end else if (ZERO_REG && (bus.read_addr_1 == ADDR_WIDTH'(0))) begin
            bus.read_data_1 = '0;
        end else if (write_ok && (bus.write_addr == bus.read_addr_1)) begin
            bus.read_data_1 = bus.write_data;
        end
    end
endmodule
